// File: rtl/mem_port_arbiter.sv
// Shares one memory port between imem and dmem, one transaction in flight.
// Define MEM_ARB_PERF_EN to add grant and stall performance counters.
module mem_port_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_resp_valid,
    output logic [DATA_W-1:0] i_resp_data,
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic              d_req_fcn,
    input  logic [2:0]        d_req_typ,
    output logic              d_resp_valid,
    output logic [DATA_W-1:0] d_resp_data,
    output logic              m_req_valid,
    input  logic              m_req_ready,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [DATA_W-1:0] m_req_wdata,
    output logic              m_req_fcn,
    output logic [2:0]        m_req_typ,
    input  logic              m_resp_valid,
    input  logic [DATA_W-1:0] m_resp_data
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]       perf_i_grants,
    output logic [31:0]       perf_d_grants,
    output logic [31:0]       perf_stall_cycles
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] HOLD = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    logic [1:0]    r_state;
    logic          r_owner;
    logic          r_fcn;
    logic [CW-1:0] r_wait_cnt;

    logic w_idle;
    logic w_hold;
    logic w_wait;
    logic w_force;
    logic w_sel;
    logic w_src_valid;
    logic w_accept;
    logic w_done;

    assign w_idle = (r_state == IDLE);
    assign w_hold = (r_state == HOLD);
    assign w_wait = (r_state == WAIT);

    // imem wins over a pending dmem once it has lost MAX_WAIT times in a row
    assign w_force     = (r_wait_cnt == MAX_CNT) && i_req_valid;
    assign w_sel       = w_hold ? r_owner : (d_req_valid && !w_force);
    assign w_src_valid = w_sel ? d_req_valid : i_req_valid;

    assign m_req_valid = !reset && (w_idle || w_hold) && w_src_valid;
    assign m_req_addr  = !m_req_valid ? '0
                       : (w_sel ? d_req_addr : i_req_addr);
    assign m_req_wdata = (m_req_valid && w_sel) ? d_req_wdata : '0;
    assign m_req_fcn   = m_req_valid && w_sel && d_req_fcn;
    assign m_req_typ   = !m_req_valid ? 3'b000
                       : (w_sel ? d_req_typ : 3'b010);

    assign w_accept    = m_req_valid && m_req_ready;
    assign i_req_ready = w_accept && !w_sel;
    assign d_req_ready = w_accept && w_sel;

    assign w_done       = !reset && w_wait && m_resp_valid;
    assign i_resp_valid = w_done && !r_owner;
    assign i_resp_data  = i_resp_valid ? m_resp_data : '0;
    assign d_resp_valid = w_done && r_owner;
    // stores complete with an ack only, never with data
    assign d_resp_data  = (d_resp_valid && !r_fcn) ? m_resp_data : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_owner    <= 1'b0;
            r_fcn      <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (m_req_valid) begin
                        r_owner <= w_sel;
                        r_fcn   <= w_sel && d_req_fcn;
                        r_state <= m_req_ready ? WAIT : HOLD;
                        if (!w_sel) begin
                            r_wait_cnt <= '0;
                        end else if (i_req_valid && r_wait_cnt != MAX_CNT) begin
                            r_wait_cnt <= r_wait_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_accept) begin
                        r_state <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_resp_valid) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic w_stall;

    assign w_stall = (i_req_valid && !i_req_ready)
                  || (d_req_valid && !d_req_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_i_grants     <= '0;
            perf_d_grants     <= '0;
            perf_stall_cycles <= '0;
        end else begin
            if (i_req_ready) perf_i_grants <= perf_i_grants + 32'd1;
            if (d_req_ready) perf_d_grants <= perf_d_grants + 32'd1;
            if (w_stall) perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change 1ns after the rising edge; outputs are checked 1ns later.
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid;
    logic        i_req_ready;
    logic [31:0] i_req_addr;
    logic        i_resp_valid;
    logic [31:0] i_resp_data;
    logic        d_req_valid;
    logic        d_req_ready;
    logic [31:0] d_req_addr;
    logic [31:0] d_req_wdata;
    logic        d_req_fcn;
    logic [2:0]  d_req_typ;
    logic        d_resp_valid;
    logic [31:0] d_resp_data;
    logic        m_req_valid;
    logic        m_req_ready;
    logic [31:0] m_req_addr;
    logic [31:0] m_req_wdata;
    logic        m_req_fcn;
    logic [2:0]  m_req_typ;
    logic        m_resp_valid;
    logic [31:0] m_resp_data;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_resp_valid (i_resp_valid),
        .i_resp_data  (i_resp_data),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_req_fcn    (d_req_fcn),
        .d_req_typ    (d_req_typ),
        .d_resp_valid (d_resp_valid),
        .d_resp_data  (d_resp_data),
        .m_req_valid  (m_req_valid),
        .m_req_ready  (m_req_ready),
        .m_req_addr   (m_req_addr),
        .m_req_wdata  (m_req_wdata),
        .m_req_fcn    (m_req_fcn),
        .m_req_typ    (m_req_typ),
        .m_resp_valid (m_resp_valid),
        .m_resp_data  (m_resp_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        reset        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        d_req_valid  = 1'b0;
        d_req_addr   = '0;
        d_req_wdata  = '0;
        d_req_fcn    = 1'b0;
        d_req_typ    = 3'b000;
        m_req_ready  = 1'b0;
        m_resp_valid = 1'b0;
        m_resp_data  = '0;
        tick();
        // reset: outputs forced quiet even with live inputs
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h100;
        m_req_ready  = 1'b1;
        m_resp_valid = 1'b1;
        settle();
        chk("rst_i_ready", i_req_ready, 0);
        chk("rst_m_valid", m_req_valid, 0);
        chk("rst_m_addr", m_req_addr, 0);
        chk("rst_i_resp", i_resp_valid, 0);
        tick();
        chk("rst_cnt", dut.r_wait_cnt, 0);
        m_resp_valid = 1'b0;
        reset        = 1'b0;

        // 1: imem only
        settle();
        chk("t1_i_ready", i_req_ready, 1);
        chk("t1_m_valid", m_req_valid, 1);
        chk("t1_m_addr", m_req_addr, 32'h100);
        chk("t1_m_fcn", m_req_fcn, 0);
        chk("t1_m_typ", m_req_typ, 3'b010);
        tick();
        i_req_valid = 1'b0;
        settle();
        chk("t1_wait_m_valid", m_req_valid, 0);
        tick();
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h13;
        settle();
        chk("t1_i_resp_v", i_resp_valid, 1);
        chk("t1_i_resp_d", i_resp_data, 32'h13);
        chk("t1_d_resp_v", d_resp_valid, 0);
        tick();
        m_resp_valid = 1'b0;
        settle();
        chk("t1_after_resp", i_resp_valid, 0);

        // 2: both valid, dmem wins first
        i_req_valid = 1'b1;
        i_req_addr  = 32'h104;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h300;
        d_req_typ   = 3'b011;
        settle();
        chk("t2_d_ready", d_req_ready, 1);
        chk("t2_i_ready", i_req_ready, 0);
        chk("t2_m_addr", m_req_addr, 32'h300);
        chk("t2_m_typ", m_req_typ, 3'b011);
        tick();
        d_req_valid = 1'b0;
        chk("t2_cnt1", dut.r_wait_cnt, 1);
        settle();
        chk("t2_wait_i_ready", i_req_ready, 0);
        tick();
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h55;
        settle();
        chk("t2_d_resp_v", d_resp_valid, 1);
        chk("t2_d_resp_d", d_resp_data, 32'h55);
        chk("t2_same_cyc_i_ready", i_req_ready, 0);
        tick();
        m_resp_valid = 1'b0;
        settle();
        chk("t2_i_ready", i_req_ready, 1);
        chk("t2_i_addr", m_req_addr, 32'h104);
        tick();
        i_req_valid = 1'b0;
        chk("t2_cnt0", dut.r_wait_cnt, 0);
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h66;
        settle();
        chk("t2_i_resp_d", i_resp_data, 32'h66);
        tick();
        m_resp_valid = 1'b0;

        // 3: starvation guard, imem wins the 5th arbitration
        i_req_valid = 1'b1;
        i_req_addr  = 32'h108;
        d_req_valid = 1'b1;
        d_req_addr  = 32'h400;
        for (int k = 1; k <= 5; k++) begin
            settle();
            chk($sformatf("t3_d_ready_%0d", k), d_req_ready, k <= 4);
            chk($sformatf("t3_i_ready_%0d", k), i_req_ready, k == 5);
            tick();
            chk($sformatf("t3_cnt_%0d", k), dut.r_wait_cnt,
                (k <= 4) ? 64'(k) : 64'd0);
            if (k == 5) i_req_valid = 1'b0;
            m_resp_valid = 1'b1;
            m_resp_data  = 32'h1000 + k;
            settle();
            chk($sformatf("t3_resp_%0d", k),
                {i_resp_valid, d_resp_valid},
                (k <= 4) ? 64'b01 : 64'b10);
            tick();
            m_resp_valid = 1'b0;
        end
        d_req_valid = 1'b0;
        d_req_typ   = 3'b000;

        // 4: port stalls, grant stays with imem while dmem arrives
        i_req_valid = 1'b1;
        i_req_addr  = 32'h10C;
        m_req_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            settle();
            chk($sformatf("t4_hold_addr_%0d", c), m_req_addr, 32'h10C);
            chk($sformatf("t4_hold_rdy_%0d", c), i_req_ready, 0);
            tick();
        end
        d_req_valid = 1'b1;
        d_req_addr  = 32'h200;
        d_req_wdata = 32'hDEADBEEF;
        d_req_fcn   = 1'b1;
        d_req_typ   = 3'b010;
        settle();
        chk("t4_hold_addr_d", m_req_addr, 32'h10C);
        chk("t4_hold_fcn", m_req_fcn, 0);
        chk("t4_d_ready0", d_req_ready, 0);
        tick();
        m_req_ready = 1'b1;
        settle();
        chk("t4_i_ready", i_req_ready, 1);
        chk("t4_d_ready1", d_req_ready, 0);
        chk("t4_addr", m_req_addr, 32'h10C);
        tick();
        i_req_valid = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h77;
        settle();
        chk("t4_i_resp_d", i_resp_data, 32'h77);
        tick();
        m_resp_valid = 1'b0;

        // 5: the waiting dmem store
        settle();
        chk("t5_d_ready", d_req_ready, 1);
        chk("t5_fcn", m_req_fcn, 1);
        chk("t5_wdata", m_req_wdata, 32'hDEADBEEF);
        chk("t5_addr", m_req_addr, 32'h200);
        tick();
        d_req_valid = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h1234;
        settle();
        chk("t5_d_resp_v", d_resp_valid, 1);
        chk("t5_d_resp_d", d_resp_data, 0);
        tick();
        m_resp_valid = 1'b0;
        d_req_fcn    = 1'b0;

        // 6: reset during WAIT, late response is stray
        i_req_valid = 1'b1;
        i_req_addr  = 32'h110;
        settle();
        chk("t6_i_ready", i_req_ready, 1);
        tick();
        i_req_valid = 1'b0;
        reset       = 1'b1;
        tick();
        reset        = 1'b0;
        m_resp_valid = 1'b1;
        m_resp_data  = 32'h99;
        settle();
        chk("t6_i_resp", i_resp_valid, 0);
        chk("t6_d_resp", d_resp_valid, 0);
        chk("t6_state", dut.r_state, 0);
        chk("t6_cnt", dut.r_wait_cnt, 0);
        tick();
        m_resp_valid = 1'b0;
        chk("t6_state_after", dut.r_state, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
